// File: rtl/hex_digit_counter_if.sv
// Control and count bus of hex_digit_counter: run/direction/load in, digit codes and pulses out.
// master drives the controls, slave (the counter) drives the count.
interface hex_digit_counter_if #(
    parameter int DIGITS = 4
);
    logic                  Run;
    logic                  Up;
    logic                  Load;
    logic [4*DIGITS-1:0]   LoadVal;
    logic [4*DIGITS-1:0]   Digits;
    logic                  Step;
    logic                  Wrap;

    modport master (
        output Run, Up, Load, LoadVal,
        input  Digits, Step, Wrap
    );

    modport slave (
        input  Run, Up, Load, LoadVal,
        output Digits, Step, Wrap
    );
endinterface

// File: rtl/hex_digit_counter.sv
// Multi-digit up/down counter with prescaler producing 4-bit digit codes for Hex7seg decoders.
// Define HEXCNT_BCD_EN for decimal digits (0..9, loads clamped to 9); default is hex digits (0..F).
module hex_digit_counter #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50_000_000
) (
    input logic                Clock,
    input logic                Resetn,
    hex_digit_counter_if.slave bus
);
    localparam int W  = 4 * DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
`ifdef HEXCNT_BCD_EN
    localparam logic [3:0] DIGIT_MAX = 4'd9;
`else
    localparam logic [3:0] DIGIT_MAX = 4'hF;
`endif

    function automatic logic [W-1:0] load_digits(input logic [W-1:0] value);
        logic [W-1:0] result;
        result = value;
`ifdef HEXCNT_BCD_EN
        for (int i = 0; i < DIGITS; i++) begin
            if (value[4*i +: 4] > DIGIT_MAX) result[4*i +: 4] = DIGIT_MAX;
        end
`endif
        return result;
    endfunction

    logic [PW-1:0] prescale;
    logic [W-1:0]  digits_q;
    logic          step_q;
    logic          wrap_q;

    logic [W-1:0]  next_digits;
    logic [3:0]    digit;
    logic          carry;
    logic          step_now;

    assign step_now = bus.Run && (prescale == PRE_LAST) && !bus.Load;

    // Single-edge ripple: carry/borrow walks up from digit 0; surviving the top digit means a full roll-over.
    always_comb begin
        next_digits = digits_q;
        digit       = '0;
        carry       = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            digit = digits_q[4*i +: 4];
            if (carry) begin
                if (bus.Up) begin
                    if (digit == DIGIT_MAX) begin
                        next_digits[4*i +: 4] = 4'd0;
                    end else begin
                        next_digits[4*i +: 4] = digit + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (digit == 4'd0) begin
                        next_digits[4*i +: 4] = DIGIT_MAX;
                    end else begin
                        next_digits[4*i +: 4] = digit - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            prescale <= '0;
            digits_q <= '0;
            step_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else if (bus.Load) begin
            prescale <= '0;
            digits_q <= load_digits(bus.LoadVal);
            step_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            step_q <= step_now;
            wrap_q <= step_now && carry;
            // Run low freezes the prescaler in place so a paused period resumes where it left off.
            if (bus.Run) begin
                prescale <= (prescale == PRE_LAST) ? '0 : prescale + PW'(1);
            end
            if (step_now) begin
                digits_q <= next_digits;
            end
        end
    end

    assign bus.Digits = digits_q;
    assign bus.Step   = step_q;
    assign bus.Wrap   = wrap_q;
endmodule

// File: tb/tb_hex_digit_counter.sv
// Self-checking bench for hex_digit_counter (DIGITS=2, TICK_DIV=4): directed steps then random traffic vs an arithmetic model.
module tb_hex_digit_counter;
    localparam int DIGITS   = 2;
    localparam int TICK_DIV = 4;
`ifdef HEXCNT_BCD_EN
    localparam int BASE = 10;
    localparam logic [7:0] ALL_MAX = 8'h99;
    localparam logic [7:0] LOAD_0F = 8'h09;
`else
    localparam int BASE = 16;
    localparam logic [7:0] ALL_MAX = 8'hFF;
    localparam logic [7:0] LOAD_0F = 8'h0F;
`endif
    localparam int MODULUS = BASE * BASE;

    logic Clock;
    logic Resetn;

    hex_digit_counter_if #(.DIGITS(DIGITS)) bus ();

    hex_digit_counter #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    // Reference model: count as an integer modulo BASE**DIGITS, prescale as a plain cycle counter.
    int m_value = 0;
    int m_pre   = 0;
    bit m_step  = 1'b0;
    bit m_wrap  = 1'b0;

    function automatic int vec_to_value(input logic [7:0] v);
        int acc = 0;
        int scale = 1;
        for (int i = 0; i < DIGITS; i++) begin
            int d = int'(v[4*i +: 4]);
            if (d > BASE - 1) d = BASE - 1;
            acc += d * scale;
            scale *= BASE;
        end
        return acc;
    endfunction

    function automatic logic [7:0] value_to_vec(input int value);
        logic [7:0] v = '0;
        int rest = value;
        for (int i = 0; i < DIGITS; i++) begin
            v[4*i +: 4] = 4'(rest % BASE);
            rest = rest / BASE;
        end
        return v;
    endfunction

    task automatic model_edge();
        if (!Resetn) begin
            m_value = 0; m_pre = 0; m_step = 0; m_wrap = 0;
        end else if (bus.Load) begin
            m_value = vec_to_value(bus.LoadVal); m_pre = 0; m_step = 0; m_wrap = 0;
        end else if (bus.Run && m_pre == TICK_DIV - 1) begin
            m_pre  = 0;
            m_step = 1;
            if (bus.Up) begin
                m_wrap  = (m_value == MODULUS - 1);
                m_value = (m_value + 1) % MODULUS;
            end else begin
                m_wrap  = (m_value == 0);
                m_value = (m_value + MODULUS - 1) % MODULUS;
            end
        end else begin
            if (bus.Run) m_pre++;
            m_step = 0;
            m_wrap = 0;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        model_edge();
        #1;
        check("model_digits", bus.Digits, value_to_vec(m_value));
        check("model_step", {7'd0, bus.Step}, {7'd0, m_step});
        check("model_wrap", {7'd0, bus.Wrap}, {7'd0, m_wrap});
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_load(input logic [7:0] v);
        bus.Load = 1'b1; bus.LoadVal = v;
        tick();
        bus.Load = 1'b0;
    endtask

    int step_count;

    initial begin
        Resetn = 1'b0; bus.Run = 1'b1; bus.Up = 1'b1; bus.Load = 1'b1; bus.LoadVal = 8'h5A;
        tick();
        check("reset_digits", bus.Digits, 8'h00);
        check("reset_step", {7'd0, bus.Step}, 8'h00);
        check("reset_wrap", {7'd0, bus.Wrap}, 8'h00);

        // Free run up from zero: one step per TICK_DIV cycles.
        Resetn = 1'b1; bus.Load = 1'b0;
        step_count = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.Step) step_count++;
            check("run_step_phase", {7'd0, bus.Step}, {7'd0, (k % 4) == 3});
        end
        check("run_step_count", 8'(step_count), 8'd3);
        check("run_digits", bus.Digits, 8'h03);

        do_load(8'h0F);
        check("load_0f", bus.Digits, LOAD_0F);
        ticks(4);
        check("load_0f_step", bus.Digits, 8'h10);
        check("load_0f_wrap", {7'd0, bus.Wrap}, 8'h00);

        do_load(8'hFF);
        check("load_ff", bus.Digits, ALL_MAX);
        ticks(4);
        check("up_roll_digits", bus.Digits, 8'h00);
        check("up_roll_wrap", {7'd0, bus.Wrap}, 8'h01);
        tick();
        check("up_roll_wrap_clear", {7'd0, bus.Wrap}, 8'h00);
        bus.Up = 1'b0;
        ticks(3);
        check("down_roll_digits", bus.Digits, ALL_MAX);
        check("down_roll_wrap", {7'd0, bus.Wrap}, 8'h01);

        // Pause mid-period: held count, step two cycles after resume.
        bus.Up = 1'b1;
        do_load(8'h20);
        ticks(2);
        bus.Run = 1'b0;
        ticks(10);
        check("hold_digits", bus.Digits, 8'h20);
        bus.Run = 1'b1;
        tick();
        check("resume_no_step", {7'd0, bus.Step}, 8'h00);
        tick();
        check("resume_step", {7'd0, bus.Step}, 8'h01);
        check("resume_digits", bus.Digits, 8'h21);

        // Run dropped on the step cycle: step fires on first Run cycle back.
        ticks(3);
        bus.Run = 1'b0;
        ticks(3);
        check("drop_hold", bus.Digits, 8'h21);
        bus.Run = 1'b1;
        tick();
        check("drop_step", bus.Digits, 8'h22);

        // Load beats a coincident step.
        ticks(3);
        do_load(8'h42);
        check("load_on_step", bus.Digits, 8'h42);
        check("load_on_step_step", {7'd0, bus.Step}, 8'h00);
        ticks(4);
        check("after_load_step", bus.Digits, 8'h43);

        // Mid-period reset discards the partial prescale.
        ticks(2);
        Resetn = 1'b0;
        tick();
        Resetn = 1'b1;
        ticks(3);
        check("reset_prescale_pending", bus.Digits, 8'h00);
        tick();
        check("reset_prescale_step", bus.Digits, 8'h01);

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            bus.Run     = ($urandom_range(0, 9) != 0);
            bus.Up      = $urandom_range(0, 1) == 1;
            bus.Load    = ($urandom_range(0, 29) == 0);
            bus.LoadVal = 8'($urandom);
            Resetn      = ($urandom_range(0, 99) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
